systolic_pe_os: RTL

- Parametrised output-stationary multiply-accumulate PE for the systolic array matrix multiplier.
- Replaces the fixed 4-bit LUT-based PE with a true signed or unsigned multiplier and a 2-stage pipeline.
- Adds valid/last framing, a configurable-width accumulator with saturate or wrap, a sticky overflow flag, and a ready/valid result drain chain. Results shift out along a PE row, with the local result taking priority over the chained result.

---
 rtl/systolic_pe_os.sv | 128 ++++++++++++
 1 files changed

// File: rtl/systolic_pe_os.sv
// Output-stationary signed/unsigned MAC PE with a 2-stage pipeline, saturating or wrapping
// accumulator, sticky overflow, and a ready/valid result drain chain along the PE row.
module systolic_pe_os #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2*DATA_W + 4,
    parameter int SIGNED = 1,
    parameter int SAT_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_valid,
    input  logic              in_last,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              out_valid,
    output logic              out_last,
    input  logic [ACC_W-1:0]  res_in_data,
    input  logic              res_in_ovf,
    input  logic              res_in_valid,
    output logic              res_in_ready,
    output logic [ACC_W-1:0]  res_out_data,
    output logic              res_out_ovf,
    output logic              res_out_valid,
    input  logic              res_out_ready,
    output logic              err_overrun
);
    localparam int PW  = 2*DATA_W;
    localparam int EXT = ACC_W + 1 - PW;

    logic [DATA_W-1:0] r_a, r_b;
    logic              r_valid, r_last;
    logic [PW-1:0]     r_p1;
    logic              r_v1, r_l1;
    logic [ACC_W-1:0]  r_acc;
    logic              r_ovf_acc, r_first;
    logic [ACC_W-1:0]  r_loc_data;
    logic              r_loc_ovf, r_loc_full, r_err;

    logic [PW-1:0]     w_a_ext, w_b_ext, w_prod;
    logic [ACC_W:0]    w_p1_ext, w_acc_ext, w_sum;
    logic [ACC_W-1:0]  w_sat, w_result;
    logic              w_ovf_step, w_ovf_acc_new, w_complete;

    // Extending both operands to the product width makes one truncated multiply correct
    // for either signedness.
    always_comb begin
        w_a_ext  = {{DATA_W{(SIGNED != 0) & in_a[DATA_W-1]}}, in_a};
        w_b_ext  = {{DATA_W{(SIGNED != 0) & in_b[DATA_W-1]}}, in_b};
        w_prod   = w_a_ext * w_b_ext;
        w_p1_ext = {{EXT{(SIGNED != 0) & r_p1[PW-1]}}, r_p1};
        w_acc_ext = r_first ? '0 : {(SIGNED != 0) & r_acc[ACC_W-1], r_acc};
        w_sum    = w_acc_ext + w_p1_ext;
        if (SIGNED != 0) begin
            w_ovf_step = (w_sum[ACC_W] != w_sum[ACC_W-1]);
            w_sat      = {w_sum[ACC_W], {(ACC_W-1){~w_sum[ACC_W]}}};
        end else begin
            w_ovf_step = w_sum[ACC_W];
            w_sat      = '1;
        end
        w_result      = ((SAT_EN != 0) && w_ovf_step) ? w_sat : w_sum[ACC_W-1:0];
        w_ovf_acc_new = (r_first ? 1'b0 : r_ovf_acc) | w_ovf_step;
        w_complete    = r_v1 & r_l1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_p1       <= '0;
            r_v1       <= 1'b0;
            r_l1       <= 1'b0;
            r_acc      <= '0;
            r_ovf_acc  <= 1'b0;
            r_first    <= 1'b1;
            r_loc_data <= '0;
            r_loc_ovf  <= 1'b0;
            r_loc_full <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_valid <= in_valid;
            r_last  <= in_valid & in_last;
            r_p1    <= w_prod;
            r_v1    <= in_valid;
            r_l1    <= in_valid & in_last;
            if (r_v1) begin
                r_acc     <= w_result;
                r_ovf_acc <= w_ovf_acc_new;
                r_first   <= r_l1;
            end
            // A completion coinciding with a drain reloads the register and keeps it full.
            if (w_complete) begin
                r_loc_data <= w_result;
                r_loc_ovf  <= w_ovf_acc_new;
                r_loc_full <= 1'b1;
                if (r_loc_full && !res_out_ready)
                    r_err <= 1'b1;
            end else if (r_loc_full && res_out_ready) begin
                r_loc_full <= 1'b0;
            end
        end
    end

    always_comb begin
        out_a       = r_a;
        out_b       = r_b;
        out_valid   = r_valid;
        out_last    = r_last;
        err_overrun = r_err;
        if (r_loc_full) begin
            res_out_data  = r_loc_data;
            res_out_ovf   = r_loc_ovf;
            res_out_valid = 1'b1;
            res_in_ready  = 1'b0;
        end else begin
            res_out_data  = res_in_data;
            res_out_ovf   = res_in_ovf;
            res_out_valid = res_in_valid;
            res_in_ready  = res_out_ready;
        end
    end

endmodule
